// File: rtl/pixel_dispatcher.sv
// Hands raster-order pixel coordinates to idle engines using round-robin arbitration.
// Optional macro PIXEL_DISPATCH_AUTORESTART_EN: start the next frame automatically after DONE.
`timescale 1ns/1ps
module pixel_dispatcher #(
  parameter int DATA_WIDTH    = 32,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int NUM_ENGINES   = 6,
  parameter int ENGINE_BITS   = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   hold,
  input  logic [NUM_ENGINES-1:0] engine_idle,
  output logic [NUM_ENGINES-1:0] assign_valid,
  output logic [DATA_WIDTH-1:0]  xpixel_o,
  output logic [DATA_WIDTH-1:0]  ypixel_o,
  output logic                   busy,
  output logic                   frame_done
);

  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_e;

  state_e                 state_q;
  logic [NUM_ENGINES-1:0] valid_q;
  logic [DATA_WIDTH-1:0]  xOut_q;
  logic [DATA_WIDTH-1:0]  yOut_q;
  logic                   busy_q;
  logic                   done_q;
  logic [DATA_WIDTH-1:0]  x_q;
  logic [DATA_WIDTH-1:0]  y_q;
  logic [NUM_ENGINES-1:0] claimed_q;
  logic [NUM_ENGINES-1:0] claimed_d;
  logic [ENGINE_BITS-1:0] ptr_q;

  logic [NUM_ENGINES-1:0] eligible;
  logic [NUM_ENGINES-1:0] grantOneHot;
  logic [ENGINE_BITS-1:0] grantIdx;
  logic [ENGINE_BITS-1:0] candIdx;
  logic                   grantFound;
  logic                   doGrant;
  logic                   lastCol;
  logic                   lastRow;

  assign eligible = engine_idle & ~claimed_q;
  assign lastCol  = (x_q == DATA_WIDTH'(SCREEN_WIDTH - 1));
  assign lastRow  = (y_q == DATA_WIDTH'(SCREEN_HEIGHT - 1));

  // A claim survives until the engine drops idle, so a just-granted engine is never granted twice.
  always_comb begin
    grantFound  = 1'b0;
    grantIdx    = ptr_q;
    candIdx     = ptr_q;
    grantOneHot = '0;
    for (int k = 1; k <= NUM_ENGINES; k++) begin
      candIdx = ENGINE_BITS'((int'(ptr_q) + k) % NUM_ENGINES);
      if (!grantFound && eligible[candIdx]) begin
        grantFound = 1'b1;
        grantIdx   = candIdx;
      end
    end
    if (grantFound) begin
      grantOneHot[grantIdx] = 1'b1;
    end
    doGrant   = (state_q == DISPATCH) && !hold && grantFound;
    claimed_d = (claimed_q & engine_idle) | (doGrant ? grantOneHot : '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      valid_q   <= '0;
      xOut_q    <= '0;
      yOut_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      claimed_q <= '0;
      ptr_q     <= ENGINE_BITS'(NUM_ENGINES - 1);
    end else begin
      valid_q   <= '0;
      done_q    <= 1'b0;
      claimed_q <= claimed_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= DISPATCH;
            busy_q  <= 1'b1;
            x_q     <= '0;
            y_q     <= '0;
          end
        end
        DISPATCH: begin
          if (doGrant) begin
            valid_q <= grantOneHot;
            xOut_q  <= x_q;
            yOut_q  <= y_q;
            ptr_q   <= grantIdx;
            if (lastCol) begin
              x_q <= '0;
              if (lastRow) begin
                y_q     <= '0;
                state_q <= DRAIN;
              end else begin
                y_q <= y_q + 1'b1;
              end
            end else begin
              x_q <= x_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if ((&engine_idle) && (claimed_q == '0)) begin
            state_q <= DONE;
`ifdef PIXEL_DISPATCH_AUTORESTART_EN
            busy_q  <= 1'b1;
`else
            busy_q  <= 1'b0;
`endif
          end
        end
        DONE: begin
          done_q <= 1'b1;
`ifdef PIXEL_DISPATCH_AUTORESTART_EN
          state_q <= DISPATCH;
          x_q     <= '0;
          y_q     <= '0;
`else
          state_q <= IDLE;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign assign_valid = valid_q;
  assign xpixel_o     = xOut_q;
  assign ypixel_o     = yOut_q;
  assign busy         = busy_q;
  assign frame_done   = done_q;

endmodule

// File: doc/pixel_dispatcher.md
Name: pixel_dispatcher

Overview:
Hands out raster-order pixel coordinates to NUM_ENGINES colour-computing engines, one assignment per cycle, using round-robin arbitration over the idle engines. It sits upstream of the engine array; the pixel combiner downstream collects results in raster order. Assignment is strictly in raster order, so the oldest outstanding pixel is always held by some engine and the combiner cannot deadlock.

Parameters:
DATA_WIDTH, 32, width of the pixel coordinate buses
SCREEN_WIDTH, 640, pixels per line
SCREEN_HEIGHT, 480, lines per frame
NUM_ENGINES, 6, number of engines served
ENGINE_BITS, 3, width of the round-robin pointer (>= clog2(NUM_ENGINES))

Ports:
clk  input  1  system clock, all state on the rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  begin a frame; sampled only in IDLE
hold  input  1  backpressure from the combiner; no new assignment while high
engine_idle  input  NUM_ENGINES  engine i can accept a pixel
assign_valid  output  NUM_ENGINES  one-hot, 1-cycle pulse: engine i must latch the coordinates
xpixel_o  output  DATA_WIDTH  assigned x, valid with assign_valid
ypixel_o  output  DATA_WIDTH  assigned y, valid with assign_valid
busy  output  1  high in DISPATCH and DRAIN
frame_done  output  1  1-cycle pulse when the frame is fully dispatched and all engines are idle

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE.
  - assign_valid, xpixel_o, ypixel_o, busy, frame_done and the x/y counters all go to 0.
  - The claimed mask is cleared.
  - The round-robin pointer is set to NUM_ENGINES-1, so engine 0 has first priority.
  - Reset asserted mid-frame abandons the frame; no frame_done is produced.
- All outputs are registered. assign_valid defaults to 0 every cycle.
- Eligibility: engine i is eligible when engine_idle[i]=1 and claimed[i]=0.
  - claimed[i] is set on the edge that asserts assign_valid[i].
  - claimed[i] is cleared on any edge where engine_idle[i]=0, i.e. the engine has acknowledged.
  - This stops a double grant while idle is still high in the cycle after an assignment.
- FSM states: IDLE, DISPATCH, DRAIN, DONE.
  - IDLE -> DISPATCH on start=1; x and y are set to 0.
  - DISPATCH, on each edge with hold=0 and at least one eligible engine:
    - Grant g = the first eligible engine searching upward from pointer+1, wrapping modulo NUM_ENGINES.
    - assign_valid[g]<=1; xpixel_o<=x; ypixel_o<=y; pointer<=g.
    - Advance the counters: x+1, or x=0 and y+1 when x==SCREEN_WIDTH-1.
  - DISPATCH -> DRAIN on the edge that assigns (SCREEN_WIDTH-1, SCREEN_HEIGHT-1); the counters return to 0.
  - DRAIN -> DONE when every engine_idle=1 and claimed is all-zero.
  - DONE: frame_done<=1 for exactly one cycle, then go to IDLE.
- Latency:
  - start sampled at edge k puts the FSM in DISPATCH.
  - The first assign_valid is visible after edge k+1, if an engine is eligible.
- Throughput: at most one assignment per cycle, whatever the number of idle engines.
- hold=1 in DISPATCH freezes the counters and pointer and asserts no grant; claimed still updates normally.
- start outside IDLE is ignored.
- Counters are DATA_WIDTH wide. y never exceeds SCREEN_HEIGHT-1 and x never exceeds SCREEN_WIDTH-1.

Optional Feature:
PIXEL_DISPATCH_AUTORESTART_EN
- Defined: DONE goes directly to DISPATCH with the counters at 0 and does not wait for start. frame_done still pulses once per frame and busy stays high across frames. A low reset remains the only way back to IDLE.
- Undefined: DONE -> IDLE, and each frame needs a new start.

Test Plan:
- Reset low mid-dispatch (use 8x4 screen) -> all outputs 0 immediately (asynchronous); after release, start gives a first grant to engine 0 at (0,0).
- All 6 engines idle, each dropping idle 1 cycle after its grant; pulse start -> assign_valid = 000001, 000010, ... 100000 on consecutive cycles with coordinates (0,0)..(5,0); no double grant.
- Only engine 3 ever idle, returning to idle 3 cycles after each grant -> every grant goes to engine 3, x increments by 1 per grant, and the cycles between grants have assign_valid=0.
- Default 640x480: grant with x=639, y=0, then the next grant has x=0, y=1; after grant (639,479), busy stays high in DRAIN until all engines are idle, then frame_done pulses for 1 cycle and busy drops.
- hold=1 for 10 cycles during DISPATCH with all engines idle -> no grants and counters unchanged; hold=0 -> dispatch resumes from the same coordinate with the round-robin order preserved.
- PIXEL_DISPATCH_AUTORESTART_EN defined, 8x4 screen -> after frame_done, a grant to the next round-robin engine at (0,0) follows with no start; two frame_done pulses after 2 frames.
